// File: rtl/axis_burst_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axis_burst_scheduler
// Purpose  : Gates a free-running AXI4-Stream into bursts of cfg_length
//            samples, separated by cfg_gap dropped samples, with an optional
//            external trigger before the first burst.
// Revision : 1.0  initial release
// ============================================================================
module axis_burst_scheduler #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 32,
    parameter int TRG_ENABLE       = 1
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [CNTR_WIDTH-1:0]       cfg_length,
    input  logic [CNTR_WIDTH-1:0]       cfg_gap,
    input  logic [CNTR_WIDTH-1:0]       cfg_bursts,
    input  logic                        ctrl_start,
    input  logic                        ctrl_stop,
    input  logic                        trg_in,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic                        sts_busy,
    output logic                        sts_done,
    output logic [CNTR_WIDTH-1:0]       sts_bursts
);

    localparam logic [CNTR_WIDTH-1:0] c_one = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_BURST = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNTR_WIDTH-1:0] r_len;
    logic [CNTR_WIDTH-1:0] r_gap;
    logic [CNTR_WIDTH-1:0] r_bursts;
    logic [CNTR_WIDTH-1:0] r_smp_cnt;
    logic [CNTR_WIDTH-1:0] r_gap_cnt;
    logic [CNTR_WIDTH-1:0] r_sts_bursts;
    logic                  r_trg_prev;
    logic                  r_stop_pend;
    logic                  r_done;

    logic                  w_in_burst;
    logic                  w_start_ok;
    logic                  w_trg_edge;
    logic                  w_beat;
    logic                  w_at_last;
    logic                  w_last_beat;
    logic                  w_end_run;
    logic                  w_gap_last;
    logic [CNTR_WIDTH-1:0] w_bursts_inc;

    // A simultaneous stop cancels a start so the block never launches a run it must abort.
    assign w_start_ok   = ctrl_start && !ctrl_stop && (cfg_length != '0);
    assign w_trg_edge   = trg_in && !r_trg_prev;
    assign w_in_burst   = (r_state == S_BURST);
    assign w_beat       = w_in_burst && s_axis_tvalid && m_axis_tready;
    assign w_at_last    = (r_smp_cnt == (r_len - c_one));
    assign w_last_beat  = w_beat && w_at_last;
    assign w_bursts_inc = r_sts_bursts + c_one;
    assign w_end_run    = ((r_bursts != '0) && (w_bursts_inc == r_bursts)) || r_stop_pend || ctrl_stop;
    assign w_gap_last   = (r_state == S_GAP) && s_axis_tvalid && (r_gap_cnt == (r_gap - c_one));

    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tvalid = w_in_burst && s_axis_tvalid;
    assign m_axis_tlast  = w_in_burst && w_at_last;
    assign s_axis_tready = w_in_burst ? m_axis_tready : 1'b1;
    assign sts_busy      = (r_state != S_IDLE);
    assign sts_done      = r_done;
    assign sts_bursts    = r_sts_bursts;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    if (TRG_ENABLE != 0) w_state_nxt = S_ARMED;
                    else                 w_state_nxt = S_BURST;
                end
            end
            S_ARMED: begin
                if (ctrl_stop)       w_state_nxt = S_IDLE;
                else if (w_trg_edge) w_state_nxt = S_BURST;
            end
            S_BURST: begin
                if (w_last_beat) begin
                    if (w_end_run)          w_state_nxt = S_IDLE;
                    else if (r_gap == '0)   w_state_nxt = S_BURST;
                    else                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (ctrl_stop)       w_state_nxt = S_IDLE;
                else if (w_gap_last) w_state_nxt = S_BURST;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_gap        <= '0;
            r_bursts     <= '0;
            r_smp_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_sts_bursts <= '0;
            r_trg_prev   <= 1'b0;
            r_stop_pend  <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_trg_prev <= trg_in;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_len        <= cfg_length;
                        r_gap        <= cfg_gap;
                        r_bursts     <= cfg_bursts;
                        r_sts_bursts <= '0;
                        r_smp_cnt    <= '0;
                        r_gap_cnt    <= '0;
                        r_stop_pend  <= 1'b0;
                    end
                end
                S_ARMED: begin
                    if (ctrl_stop) r_done <= 1'b1;
                end
                S_BURST: begin
                    // Stop never truncates a burst; it is honoured at the next tlast.
                    if (ctrl_stop) r_stop_pend <= 1'b1;
                    if (w_beat) r_smp_cnt <= w_at_last ? '0 : (r_smp_cnt + c_one);
                    if (w_last_beat) begin
                        r_sts_bursts <= w_bursts_inc;
                        if (w_end_run) begin
                            r_done      <= 1'b1;
                            r_stop_pend <= 1'b0;
                        end
                    end
                end
                S_GAP: begin
                    if (ctrl_stop)          r_done    <= 1'b1;
                    else if (s_axis_tvalid) r_gap_cnt <= w_gap_last ? '0 : (r_gap_cnt + c_one);
                end
                default: r_done <= 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_burst_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axis_burst_scheduler
// Purpose  : Drives two schedulers (trigger disabled / enabled) from shared
//            stimulus and checks both against a transaction-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_axis_burst_scheduler;

    localparam int DW = 32;
    localparam int CW = 32;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic [CW-1:0] cfg_length = '0, cfg_gap = '0, cfg_bursts = '0;
    logic          ctrl_start = 1'b0, ctrl_stop = 1'b0, trg_in = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0, m_tready = 1'b1;

    logic          s_tready [2];
    logic [DW-1:0] m_tdata [2];
    logic          m_tvalid [2], m_tlast [2], sts_busy [2], sts_done [2];
    logic [CW-1:0] sts_bursts [2];

    always #5 aclk = ~aclk;

    axis_burst_scheduler #(.AXIS_TDATA_WIDTH(DW), .CNTR_WIDTH(CW), .TRG_ENABLE(0)) u_dut0 (
        .aclk(aclk), .areset(areset), .cfg_length(cfg_length), .cfg_gap(cfg_gap),
        .cfg_bursts(cfg_bursts), .ctrl_start(ctrl_start), .ctrl_stop(ctrl_stop), .trg_in(trg_in),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready[0]),
        .m_axis_tdata(m_tdata[0]), .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast[0]), .sts_busy(sts_busy[0]), .sts_done(sts_done[0]),
        .sts_bursts(sts_bursts[0]));

    axis_burst_scheduler #(.AXIS_TDATA_WIDTH(DW), .CNTR_WIDTH(CW), .TRG_ENABLE(1)) u_dut1 (
        .aclk(aclk), .areset(areset), .cfg_length(cfg_length), .cfg_gap(cfg_gap),
        .cfg_bursts(cfg_bursts), .ctrl_start(ctrl_start), .ctrl_stop(ctrl_stop), .trg_in(trg_in),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready[1]),
        .m_axis_tdata(m_tdata[1]), .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast[1]), .sts_busy(sts_busy[1]), .sts_done(sts_done[1]),
        .sts_bursts(sts_bursts[1]));

    int checks = 0;
    int errors = 0;

    // Model: mode 0 idle, 1 waiting for trigger, 2 passing samples, 3 dropping samples.
    int            md [2];
    logic [CW-1:0] len [2], gap [2], nb [2], pos [2], gap_left [2], nburst [2];
    bit            stop_pend [2], trg_prev [2], done_exp [2];

    int            beats [2], lasts [2], dones [2];
    bit            got_first [2];
    logic [DW-1:0] first_data [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int i);
        md[i] = 0; len[i] = '0; gap[i] = '0; nb[i] = '0; pos[i] = '0;
        gap_left[i] = '0; nburst[i] = '0; stop_pend[i] = 0; trg_prev[i] = 0; done_exp[i] = 0;
    endtask

    task automatic model_advance(input int i);
        bit done_n;
        done_n = 0;
        case (md[i])
            0: if (ctrl_start && !ctrl_stop && cfg_length != '0) begin
                len[i] = cfg_length; gap[i] = cfg_gap; nb[i] = cfg_bursts;
                nburst[i] = '0; pos[i] = '0; stop_pend[i] = 0;
                md[i] = (i == 1) ? 1 : 2;
            end
            1: if (ctrl_stop) begin md[i] = 0; done_n = 1; end
               else if (trg_in && !trg_prev[i]) md[i] = 2;
            2: begin
                if (ctrl_stop) stop_pend[i] = 1;
                if (s_tvalid && m_tready) begin
                    pos[i] = pos[i] + 1;
                    if (pos[i] == len[i]) begin
                        pos[i] = '0;
                        nburst[i] = nburst[i] + 1;
                        if ((nb[i] != '0 && nburst[i] == nb[i]) || stop_pend[i]) begin
                            md[i] = 0; done_n = 1;
                        end else if (gap[i] != '0) begin
                            md[i] = 3; gap_left[i] = gap[i];
                        end
                    end
                end
            end
            default: if (ctrl_stop) begin md[i] = 0; done_n = 1; end
               else if (s_tvalid) begin
                   gap_left[i] = gap_left[i] - 1;
                   if (gap_left[i] == '0) md[i] = 2;
               end
        endcase
        done_exp[i] = done_n;
        trg_prev[i] = trg_in;
    endtask

    task automatic step();
        bit e_valid;
        for (int i = 0; i < 2; i++) begin
            if (areset) begin
                model_reset(i);
                chk($sformatf("rst_tvalid[%0d]", i), m_tvalid[i], 0);
                chk($sformatf("rst_tlast[%0d]", i), m_tlast[i], 0);
                chk($sformatf("rst_busy[%0d]", i), sts_busy[i], 0);
                chk($sformatf("rst_done[%0d]", i), sts_done[i], 0);
                chk($sformatf("rst_bursts[%0d]", i), sts_bursts[i], 0);
            end else begin
                e_valid = (md[i] == 2) && s_tvalid;
                chk($sformatf("s_tready[%0d]", i), s_tready[i], (md[i] == 2) ? m_tready : 1'b1);
                chk($sformatf("m_tvalid[%0d]", i), m_tvalid[i], e_valid);
                chk($sformatf("m_tlast[%0d]", i), m_tlast[i], (md[i] == 2) && (pos[i] == len[i] - 1));
                chk($sformatf("busy[%0d]", i), sts_busy[i], md[i] != 0);
                chk($sformatf("done[%0d]", i), sts_done[i], done_exp[i]);
                chk($sformatf("bursts[%0d]", i), sts_bursts[i], nburst[i]);
                if (e_valid) chk($sformatf("m_tdata[%0d]", i), m_tdata[i], s_tdata);
                if (m_tvalid[i] && m_tready) begin
                    beats[i]++;
                    if (m_tlast[i]) lasts[i]++;
                    if (!got_first[i]) begin got_first[i] = 1; first_data[i] = m_tdata[i]; end
                end
                if (sts_done[i]) dones[i]++;
                model_advance(i);
            end
        end
    endtask

    task automatic cycle();
        @(negedge aclk);
        step();
        @(posedge aclk);
        #1;
        ctrl_start = 1'b0;
        ctrl_stop  = 1'b0;
        s_tdata    = $urandom;
    endtask

    task automatic wait_idle(input int i, input int bound);
        int n;
        n = 0;
        while (sts_busy[i] && n < bound) begin cycle(); n++; end
        if (sts_busy[i]) begin
            checks++; errors++;
            $display("FAIL timeout_idle[%0d] actual=busy required=idle within %0d cycles", i, bound);
        end
    endtask

    task automatic clear_mon();
        for (int i = 0; i < 2; i++) begin
            beats[i] = 0; lasts[i] = 0; dones[i] = 0; got_first[i] = 0;
        end
    endtask

    task automatic settle();
        ctrl_stop = 1'b1;
        s_tvalid = 1'b1; m_tready = 1'b1;
        cycle();
        wait_idle(0, 200);
        wait_idle(1, 200);
        cycle();
        clear_mon();
    endtask

    logic [DW-1:0] exp_first;
    int            n;

    initial begin
        for (int i = 0; i < 2; i++) model_reset(i);
        clear_mon();
        repeat (3) cycle();
        areset = 1'b0;
        cycle();
        chk("reset_busy0", sts_busy[0], 0);
        chk("reset_bursts0", sts_bursts[0], 0);

        // Fixed 4/2/3 run without trigger.
        settle();
        cfg_length = 4; cfg_gap = 2; cfg_bursts = 3; trg_in = 0;
        ctrl_start = 1'b1;
        cycle();
        wait_idle(0, 100);
        repeat (2) cycle();
        chk("s1_beats", beats[0], 12);
        chk("s1_lasts", lasts[0], 3);
        chk("s1_bursts", sts_bursts[0], 3);
        chk("s1_done", dones[0], 1);
        chk("s1_busy", sts_busy[0], 0);
        chk("s1_trg_idle_out", beats[1], 0);

        // Trigger already high at start must not fire; only a fresh rising edge does.
        settle();
        cfg_length = 3; cfg_gap = 1; cfg_bursts = 1; trg_in = 1;
        repeat (2) cycle();
        ctrl_start = 1'b1;
        cycle();
        repeat (3) cycle();
        trg_in = 0;
        repeat (2) cycle();
        chk("s2_no_early_out", beats[1], 0);
        trg_in = 1;
        cycle();
        exp_first = s_tdata;
        cycle();
        wait_idle(1, 50);
        repeat (2) cycle();
        chk("s2_got_first", got_first[1], 1);
        chk("s2_first_data", first_data[1], exp_first);
        chk("s2_beats", beats[1], 3);
        chk("s2_bursts", sts_bursts[1], 1);
        chk("s2_done", dones[1], 1);

        // Back-to-back bursts under toggling backpressure.
        settle();
        cfg_length = 3; cfg_gap = 0; cfg_bursts = 2; trg_in = 0;
        ctrl_start = 1'b1;
        cycle();
        n = 0;
        while (sts_busy[0] && n < 60) begin m_tready = ~m_tready; cycle(); n++; end
        m_tready = 1'b1;
        repeat (2) cycle();
        chk("s3_beats", beats[0], 6);
        chk("s3_lasts", lasts[0], 2);
        chk("s3_bursts", sts_bursts[0], 2);
        chk("s3_done", dones[0], 1);

        // Stop at beat 2 of a continuous run lets the burst finish.
        settle();
        cfg_length = 5; cfg_gap = 3; cfg_bursts = 0;
        ctrl_start = 1'b1;
        cycle();
        cycle();
        ctrl_stop = 1'b1;
        cycle();
        wait_idle(0, 50);
        repeat (2) cycle();
        chk("s4_beats", beats[0], 5);
        chk("s4_lasts", lasts[0], 1);
        chk("s4_bursts", sts_bursts[0], 1);
        chk("s4_done", dones[0], 1);

        // Stop during the gap ends the run on the next cycle.
        settle();
        ctrl_start = 1'b1;
        cycle();
        n = 0;
        while (lasts[0] == 0 && n < 50) begin cycle(); n++; end
        ctrl_stop = 1'b1;
        cycle();
        chk("s4_gapstop_busy", sts_busy[0], 0);
        chk("s4_gapstop_done", sts_done[0], 1);

        // Zero length and start+stop are both ignored.
        settle();
        cfg_length = 0;
        ctrl_start = 1'b1;
        repeat (2) cycle();
        chk("s5_len0_busy0", sts_busy[0], 0);
        chk("s5_len0_busy1", sts_busy[1], 0);
        cfg_length = 4;
        ctrl_start = 1'b1; ctrl_stop = 1'b1;
        repeat (2) cycle();
        chk("s5_ss_busy0", sts_busy[0], 0);
        chk("s5_ss_busy1", sts_busy[1], 0);

        // Asynchronous reset mid-burst, then a clean restart.
        settle();
        cfg_length = 3; cfg_gap = 0; cfg_bursts = 0;
        ctrl_start = 1'b1;
        repeat (5) cycle();
        #1 areset = 1'b1;
        #1;
        chk("s6_async_tvalid", m_tvalid[0], 0);
        chk("s6_async_busy", sts_busy[0], 0);
        chk("s6_async_bursts", sts_bursts[0], 0);
        repeat (2) cycle();
        areset = 1'b0;
        cfg_length = 4; cfg_bursts = 1;
        clear_mon();
        ctrl_start = 1'b1;
        cycle();
        wait_idle(0, 50);
        repeat (2) cycle();
        chk("s6_beats", beats[0], 4);
        chk("s6_lasts", lasts[0], 1);
        chk("s6_bursts", sts_bursts[0], 1);
        chk("s6_done", dones[0], 1);

        // Randomised traffic, control and configuration churn.
        settle();
        for (int k = 0; k < 3000; k++) begin
            cfg_length = $urandom_range(0, 6);
            cfg_gap    = $urandom_range(0, 3);
            cfg_bursts = $urandom_range(0, 3);
            ctrl_start = ($urandom_range(0, 19) == 0);
            ctrl_stop  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 7) == 0) trg_in = ~trg_in;
            s_tvalid   = ($urandom_range(0, 3) != 0);
            m_tready   = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axis_burst_scheduler.md
Name: axis_burst_scheduler

Overview:
Sequences gated sample capture on a free-running AXI4-Stream (e.g. ADC data). Passes exactly cfg_length samples per burst, inserts cfg_gap discarded samples between bursts, and repeats for cfg_bursts bursts (0 = continuous). Optionally waits for an external trigger before the first burst. Sits between the ADC stream and the packet/DMA path, under control of the config/status registers.

Parameters:
AXIS_TDATA_WIDTH, 32, stream data width
CNTR_WIDTH, 32, width of length/gap/burst counters and config words
TRG_ENABLE, 1, 1 = first burst waits for trg_in rising edge; 0 = starts on ctrl_start

Ports:
aclk  input  1  clock
areset  input  1  asynchronous active-high reset
cfg_length  input  CNTR_WIDTH  samples per burst, sampled at start
cfg_gap  input  CNTR_WIDTH  discarded samples between bursts, sampled at start
cfg_bursts  input  CNTR_WIDTH  burst count; 0 = run until stop
ctrl_start  input  1  single-cycle start pulse
ctrl_stop  input  1  single-cycle stop pulse
trg_in  input  1  external trigger level, rising edge used
s_axis_tdata  input  AXIS_TDATA_WIDTH  input samples
s_axis_tvalid  input  1  input valid
s_axis_tready  output  1  input ready
m_axis_tdata  output  AXIS_TDATA_WIDTH  gated samples
m_axis_tvalid  output  1  output valid
m_axis_tready  input  1  output ready
m_axis_tlast  output  1  last sample of burst
sts_busy  output  1  high in any state except IDLE
sts_done  output  1  one-cycle pulse on normal completion or stop
sts_bursts  output  CNTR_WIDTH  completed bursts since last start

Behaviour:
- Clock aclk; reset areset is asynchronous, active-high. Reset: state IDLE, all counters 0, trigger-edge register 0, sts_busy 0, sts_done 0, sts_bursts 0, m_axis_tvalid 0, m_axis_tlast 0.
- States: IDLE, ARMED, BURST, GAP.
- IDLE: s_axis_tready=1 (input discarded). ctrl_start with cfg_length!=0: latch cfg_length/gap/bursts, clear sts_bursts, go ARMED if TRG_ENABLE else BURST. ctrl_start with cfg_length==0 ignored.
- ARMED: input discarded. trg_in 0->1 (registered previous value, one-cycle edge detect) -> BURST next cycle. A trigger already high on entry does not fire.
- BURST: m_axis_tdata=s_axis_tdata, m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready (combinational, zero latency). Sample counter increments per beat with s_axis_tvalid & m_axis_tready. m_axis_tlast=1 when counter==length-1. On last beat: sts_bursts+1; if bursts!=0 and sts_bursts+1==bursts, or stop pending -> IDLE with sts_done pulse; else gap==0 -> BURST again (counter cleared, back-to-back, no idle cycle); else GAP.
- GAP: s_axis_tready=1, m_axis_tvalid=0; gap counter increments per s_axis_tvalid beat; after gap beats -> BURST.
- Outside BURST: m_axis_tvalid=0, m_axis_tlast=0.
- ctrl_stop: in ARMED or GAP -> IDLE next cycle with sts_done pulse. In BURST -> set stop-pending; burst finishes normally (tlast never truncated), then IDLE. In IDLE ignored. Stop and start same cycle in IDLE: start ignored. ctrl_start while busy ignored.
- cfg_* changes while busy have no effect until next start.
- Counters compare with ==, no wrap; cfg_bursts=0 lets sts_bursts wrap modulo 2^CNTR_WIDTH silently.
- Output backpressure stalls input only during BURST; input never stalled otherwise.

Test Plan:
- TRG_ENABLE=0, length=4, gap=2, bursts=3, continuous valid, tready=1 -> 12 beats out as 3 groups of 4 separated by 2 dropped samples, tlast on beats 4/8/12, sts_done pulse, sts_bursts=3, sts_busy 0.
- TRG_ENABLE=1, trg_in held high before start, then low, then high -> no output until second rising edge; first output sample is the one valid in the cycle after the edge is registered.
- length=3, gap=0, bursts=2, m_axis_tready toggling 1/0 -> 6 contiguous samples, none lost or duplicated, tlast on beats 3 and 6, s_axis_tready mirrors tready.
- bursts=0, length=5, stop asserted mid-burst at beat 2 -> burst completes to beat 5 with tlast, then IDLE, sts_done pulse; stop during GAP -> IDLE next cycle.
- start with cfg_length=0 -> remains IDLE, sts_busy 0; start+stop same cycle -> remains IDLE.
- areset asserted mid-burst asynchronously -> m_axis_tvalid, sts_busy, sts_bursts 0 immediately; after release, new start runs a full clean burst.
